rca_d64_arbiter: RTL and testbench
==================================

RCA_D64_ARBITER -- requirements
Module: rca_d64_arbiter

Interface
REQ-001 Parameter: W, 64, operand width in bits; SHALL be even; the low half and high half are each W/2 bits.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req0_valid / req1_valid  input  1  requester 0/1 presents an operation.
REQ-005 req0_ready / req1_ready  output  1  operation from requester 0/1 accepted this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  W  operands of requester 0/1.
REQ-007 req0_cin / req1_cin  input  1  carry-in of requester 0/1.
REQ-008 res_valid  output  1  result is held and valid.
REQ-009 res_ready  input  1  consumer accepts the result.
REQ-010 res_sum  output  W  sum.
REQ-011 res_cout  output  1  carry-out.
REQ-012 res_id  output  1  requester that issued the result (0 or 1).
REQ-013 res_ovf  output  1  signed overflow; present only when ARB_OVF_EN is defined.

Function
REQ-014 The block SHALL share one carry-select W-bit adder between two requesters: a low-half W/2-bit adder using the real cin, plus duplicated high-half adders with cin=0 and cin=1, selected by the registered low-half carry.
REQ-015 FSM states SHALL be IDLE, LO, HI and DONE; there SHALL be no other reachable states.
REQ-016 IDLE: if any reqN_valid is high, grant one requester, assert its reqN_ready for exactly that cycle, capture a, b, cin and id, then go to LO; otherwise stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: on a contention, grant the requester not granted last; after reset, requester 0 has priority.
REQ-018 If only one requester is valid, it SHALL be granted regardless of priority.
REQ-019 LO: register the low-half sum and low-half carry-out, and both high-half candidate sums and carries, then go to HI.
REQ-020 HI: select the high-half sum and cout with the registered low carry (0 selects the cin=0 copy), load res_sum and res_cout, then go to DONE.
REQ-021 DONE: res_valid=1; res_sum, res_cout, res_id and res_ovf SHALL be stable until the handshake.
REQ-022 On res_valid and res_ready, go to IDLE; a new grant is possible in the next cycle at the earliest.
REQ-023 Latency: 3 cycles from grant to res_valid; at most one operation in flight; peak throughput is one result per 4 cycles.
REQ-024 reqN_ready SHALL never be asserted outside IDLE, and never for both requesters in the same cycle.
REQ-025 Arithmetic SHALL be unsigned modulo 2^W; res_cout is bit W of a + b + cin.
REQ-026 Wrap-around: all-ones + 0 + cin=1 SHALL give sum=0 and cout=1, which exercises the cin=1 high-half path.
REQ-027 Requester inputs SHALL be ignored after capture; changes during LO, HI or DONE have no effect on the result.
REQ-028 A requester that deasserts valid before it is granted SHALL lose its turn without changing the round-robin pointer.

Reset
REQ-029 While rst_n=0: state=IDLE, res_valid=0, res_sum=0, res_cout=0, res_id=0, res_ovf=0, both reqN_ready=0, and the priority pointer selects requester 0.
REQ-030 Reset asserted mid-operation SHALL abort the operation immediately with no result; on release the block SHALL be in IDLE.
REQ-031 Reset SHALL be asynchronous assertion, synchronous to clk on release.

Configuration
REQ-032 Macro ARB_OVF_EN defined: res_ovf is a port; in HI it is loaded with (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]) and is held like the other result fields.
REQ-033 ARB_OVF_EN undefined: the res_ovf port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-034 Single op: req0 a=5, b=7, cin=0 -> req0_ready for 1 cycle; 3 cycles later res_valid=1, res_sum=12, res_cout=0, res_id=0.
REQ-035 Carry across halves: a=0x00000000FFFFFFFF, b=1, cin=0 -> res_sum=0x0000000100000000, res_cout=0.
REQ-036 Wrap-around: a=all-ones, b=0, cin=1 -> res_sum=0, res_cout=1; with ARB_OVF_EN defined, res_ovf=0.
REQ-037 Contention: both valid continuously for 4 operations -> grant order 0,1,0,1 with correct res_id on each result.
REQ-038 Backpressure and reset: res_ready held low for 10 cycles -> result stable and no reqN_ready; then rst_n pulsed during LO -> res_valid=0 and IDLE on release.
REQ-039 Overflow (ARB_OVF_EN): a=0x7FFFFFFFFFFFFFFF, b=1 -> res_ovf=1, res_sum=0x8000000000000000.

Source files
------------

// File: rtl/rca_d64_arbiter.sv
// rca_d64_arbiter
//   Two requesters share one carry-select W-bit adder. A round-robin
//   arbiter grants one operation at a time. The operation then steps
//   through LO (low-half add plus both high-half candidates), HI (select
//   the high half with the registered low carry) and DONE (result held
//   until the consumer accepts it).
//
// Optional feature:
//   ARB_OVF_EN  when defined, adds the res_ovf port (signed overflow).
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   reqN_valid/reqN_ready  per-requester handshake (N = 0, 1)
//   reqN_a, reqN_b         W-bit operands
//   reqN_cin               carry-in
//   res_valid/res_ready    result handshake
//   res_sum, res_cout      W-bit sum and carry-out
//   res_id                 requester that issued the result
//   res_ovf                signed overflow (ARB_OVF_EN only)
module rca_d64_arbiter #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_cin,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_cin,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_sum,
    output logic         res_cout,
    output logic         res_id
`ifdef ARB_OVF_EN
    ,
    output logic         res_ovf
`endif
);

    localparam int H = W / 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_DONE
    } state_t;

    state_t         state;
    logic           prio;       // requester that wins the next contention
    logic [W-1:0]   a_q, b_q;
    logic           cin_q, id_q;
    logic [H-1:0]   lo_sum_q, hi0_sum_q, hi1_sum_q;
    logic           lo_c_q, hi0_c_q, hi1_c_q;

    logic           grant0, grant1;
    logic [H:0]     lo_full, hi0_full, hi1_full;
    logic [H-1:0]   hi_sel_sum;
    logic           hi_sel_c;

    // Grant is combinational so ready coincides with the capture edge.
    // A lone valid requester wins regardless of the pointer.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n && state == S_IDLE) begin
            grant0 = req0_valid && (!req1_valid || !prio);
            grant1 = req1_valid && (!req0_valid ||  prio);
        end
        req0_ready = grant0;
        req1_ready = grant1;
    end

    // Low half uses the real carry-in; the high half is computed for both
    // possible incoming carries and chosen one cycle later.
    always_comb begin
        lo_full  = {1'b0, a_q[H-1:0]} + {1'b0, b_q[H-1:0]} + {{H{1'b0}}, cin_q};
        hi0_full = {1'b0, a_q[W-1:H]} + {1'b0, b_q[W-1:H]};
        hi1_full = {1'b0, a_q[W-1:H]} + {1'b0, b_q[W-1:H]} + {{H{1'b0}}, 1'b1};
        hi_sel_sum = lo_c_q ? hi1_sum_q : hi0_sum_q;
        hi_sel_c   = lo_c_q ? hi1_c_q   : hi0_c_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            prio      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            cin_q     <= 1'b0;
            id_q      <= 1'b0;
            lo_sum_q  <= '0;
            hi0_sum_q <= '0;
            hi1_sum_q <= '0;
            lo_c_q    <= 1'b0;
            hi0_c_q   <= 1'b0;
            hi1_c_q   <= 1'b0;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_cout  <= 1'b0;
            res_id    <= 1'b0;
`ifdef ARB_OVF_EN
            res_ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant0 || grant1) begin
                        a_q   <= grant1 ? req1_a   : req0_a;
                        b_q   <= grant1 ? req1_b   : req0_b;
                        cin_q <= grant1 ? req1_cin : req0_cin;
                        id_q  <= grant1;
                        // The requester not just served gets priority next.
                        prio  <= grant0;
                        state <= S_LO;
                    end
                end
                S_LO: begin
                    lo_sum_q  <= lo_full[H-1:0];
                    lo_c_q    <= lo_full[H];
                    hi0_sum_q <= hi0_full[H-1:0];
                    hi0_c_q   <= hi0_full[H];
                    hi1_sum_q <= hi1_full[H-1:0];
                    hi1_c_q   <= hi1_full[H];
                    state     <= S_HI;
                end
                S_HI: begin
                    res_sum   <= {hi_sel_sum, lo_sum_q};
                    res_cout  <= hi_sel_c;
                    res_id    <= id_q;
`ifdef ARB_OVF_EN
                    res_ovf   <= (a_q[W-1] == b_q[W-1]) && (hi_sel_sum[H-1] != a_q[W-1]);
`endif
                    res_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rca_d64_arbiter.sv
module tb_rca_d64_arbiter;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_cin, req1_cin;
    logic         res_valid, res_ready;
    logic [W-1:0] res_sum;
    logic         res_cout, res_id;
`ifdef ARB_OVF_EN
    logic         res_ovf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rca_d64_arbiter #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_cout   (res_cout),
        .res_id     (res_id)
`ifdef ARB_OVF_EN
        ,
        .res_ovf    (res_ovf)
`endif
    );

    // Present one operation on one requester, wait (bounded) for its grant,
    // then drop valid and scramble the operands so late changes are visible.
    task automatic send(input bit who, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, output bit ok);
        @(posedge clk); #1;
        if (who) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
        end
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((who ? req1_ready : req0_ready) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a = {$urandom(), $urandom()};
        req0_b = {$urandom(), $urandom()};
        req1_a = {$urandom(), $urandom()};
        req1_b = {$urandom(), $urandom()};
        req0_cin = 1'($urandom());
        req1_cin = 1'($urandom());
    endtask

    // Count negedges from the grant until res_valid (bounded at 10).
    task automatic wait_res(output int lat);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (res_valid === 1'b1) break;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
        req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_a = '0; req1_b = '0; req1_cin = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b expected 0", res_valid); end
        checks++; if (res_sum !== '0) begin errors++; $display("FAIL reset_sum got %0h expected 0", res_sum); end
        checks++; if (res_cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %0b expected 0", res_cout); end
        checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL reset_id got %0b expected 0", res_id); end
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b expected 00", {req0_ready, req1_ready}); end
`ifdef ARB_OVF_EN
        checks++; if (res_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b expected 0", res_ovf); end
`endif
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        bit ok; int lat;
        send(1'b0, 64'd5, 64'd7, 1'b0, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_grant got %0b expected 1", ok); end
        wait_res(lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL single_latency got %0d expected 3", lat); end
        checks++; if (res_sum !== 64'd12) begin errors++; $display("FAIL single_sum got %0h expected c", res_sum); end
        checks++; if (res_cout !== 1'b0) begin errors++; $display("FAIL single_cout got %0b expected 0", res_cout); end
        checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL single_id got %0b expected 0", res_id); end
    endtask

    task automatic test_carry;
        bit ok; int lat;
        send(1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL carry_grant got %0b expected 1", ok); end
        wait_res(lat);
        checks++; if (res_sum !== 64'h0000_0001_0000_0000) begin errors++; $display("FAIL carry_sum got %0h expected 100000000", res_sum); end
        checks++; if (res_cout !== 1'b0) begin errors++; $display("FAIL carry_cout got %0b expected 0", res_cout); end
    endtask

    task automatic test_wrap;
        bit ok; int lat;
        send(1'b0, {W{1'b1}}, 64'd0, 1'b1, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wrap_grant got %0b expected 1", ok); end
        wait_res(lat);
        checks++; if (res_sum !== 64'd0) begin errors++; $display("FAIL wrap_sum got %0h expected 0", res_sum); end
        checks++; if (res_cout !== 1'b1) begin errors++; $display("FAIL wrap_cout got %0b expected 1", res_cout); end
`ifdef ARB_OVF_EN
        checks++; if (res_ovf !== 1'b0) begin errors++; $display("FAIL wrap_ovf got %0b expected 0", res_ovf); end
`endif
    endtask

    task automatic test_overflow;
        bit ok; int lat;
        send(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ovf_grant got %0b expected 1", ok); end
        wait_res(lat);
        checks++; if (res_sum !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL ovf_sum got %0h expected 8000000000000000", res_sum); end
        checks++; if (res_cout !== 1'b0) begin errors++; $display("FAIL ovf_cout got %0b expected 0", res_cout); end
        checks++; if (res_id !== 1'b1) begin errors++; $display("FAIL ovf_id got %0b expected 1", res_id); end
`ifdef ARB_OVF_EN
        checks++; if (res_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b expected 1", res_ovf); end
`endif
    endtask

    task automatic test_contention;
        int got, lat;
        logic both;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        req0_a = 64'd100; req0_b = 64'd1; req0_cin = 1'b0;
        req1_a = 64'd200; req1_b = 64'd2; req1_cin = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int op = 0; op < 4; op++) begin
            got = -1; both = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if ((req0_ready | req1_ready) === 1'b1) begin
                    both = req0_ready & req1_ready;
                    got = int'(req1_ready);
                    break;
                end
            end
            checks++; if (got != op % 2) begin errors++; $display("FAIL rr_grant op%0d got %0d expected %0d", op, got, op % 2); end
            checks++; if (both !== 1'b0) begin errors++; $display("FAIL rr_both_ready op%0d got %0b expected 0", op, both); end
            wait_res(lat);
            checks++; if (lat != 3) begin errors++; $display("FAIL rr_latency op%0d got %0d expected 3", op, lat); end
            checks++; if (res_id !== 1'(op % 2)) begin errors++; $display("FAIL rr_id op%0d got %0b expected %0d", op, res_id, op % 2); end
            checks++; if (res_sum !== ((op % 2) ? 64'd203 : 64'd101)) begin errors++; $display("FAIL rr_sum op%0d got %0d expected %0d", op, res_sum, (op % 2) ? 203 : 101); end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_backpressure_reset;
        bit ok; int lat;
        res_ready = 1'b0;
        send(1'b1, 64'h123, 64'h456, 1'b1, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_grant got %0b expected 1", ok); end
        req0_valid = 1'b1;
        wait_res(lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL bp_latency got %0d expected 3", lat); end
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            checks++;
            if (!(res_valid === 1'b1 && res_sum === 64'h57A && res_id === 1'b1 && res_cout === 1'b0)) begin
                errors++;
                $display("FAIL bp_hold cyc%0d got valid=%0b sum=%0h id=%0b expected valid=1 sum=57a id=1", c, res_valid, res_sum, res_id);
            end
            checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL bp_ready cyc%0d got %b expected 00", c, {req0_ready, req1_ready}); end
        end
        req0_valid = 1'b0;
        res_ready = 1'b1;
        send(1'b0, 64'd1, 64'd2, 1'b0, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL abort_grant got %0b expected 1", ok); end
        // Now in LO: pulse reset mid-cycle.
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL abort_valid_in_reset got %0b expected 0", res_valid); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL abort_no_result cyc%0d got %0b expected 0", c, res_valid); end
        end
        req0_a = 64'd100; req0_b = 64'd1; req0_cin = 1'b0;
        req1_a = 64'd200; req1_b = 64'd2; req1_cin = 1'b0;
        @(posedge clk); #1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL post_reset_grant got %b expected 10", {req0_ready, req1_ready}); end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_res(lat);
        checks++; if (res_sum !== 64'd101) begin errors++; $display("FAIL post_reset_sum got %0d expected 101", res_sum); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_carry();
        test_wrap();
        test_overflow();
        test_contention();
        test_backpressure_reset();
        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
